ro_data_receiver: RTL and testbench

//  Serial receiver for the ring-oscillator count stream: deserializes the LSB-first bit stream and

---
 rtl/ro_data_receiver.sv | 148 ++++++++++++++
 tb/tb_ro_data_receiver.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ro_data_receiver.sv
// ============================================================================
// ro_data_receiver: deserializes the RO-count serial stream into 8x32-bit frames
// Revision: 1.0
// ============================================================================
`default_nettype none

module ro_data_receiver #(
  parameter int NUM_WORDS   = 8,
  parameter int WORD_W      = 32,
  parameter int SYNC_OFFSET = 1
) (
  input  logic                        data_clk,
  input  logic                        reset,
  input  logic                        data_in,
  input  logic [1:0]                  sel_in,
  input  logic                        clear_err,
  output logic [NUM_WORDS*WORD_W-1:0] counts_out,
  output logic [1:0]                  frame_sel,
  output logic                        frame_valid,
  output logic [15:0]                 frame_count,
  output logic                        sync_err,
  output logic                        seq_err
);

  localparam int NB = NUM_WORDS * WORD_W;
  localparam int CW = $clog2(NB) + 1;

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    WAIT = 2'd1,
    RECV = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      sel_q, sel_d;
  logic [1:0]      cap_q, cap_d;
  logic            data_q, data_d;
  logic [1:0]      wcnt_q, wcnt_d;
  logic [CW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [NB-1:0]   shift_q, shift_d;
  logic [NB-1:0]   counts_q, counts_d;
  logic [1:0]      fsel_q, fsel_d;
  logic            fvalid_q, fvalid_d;
  logic [15:0]     fcount_q, fcount_d;
  logic            serr_q, serr_d;
  logic            qerr_q, qerr_d;
  logic            have_q, have_d;
  logic            edge_w;
  logic            seq_set_w;

  always_ff @(posedge data_clk or negedge reset) begin
    if (!reset) begin
      state_q   <= HUNT;
      sel_q     <= '0;
      cap_q     <= '0;
      data_q    <= 1'b0;
      wcnt_q    <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      counts_q  <= '0;
      fsel_q    <= '0;
      fvalid_q  <= 1'b0;
      fcount_q  <= '0;
      serr_q    <= 1'b0;
      qerr_q    <= 1'b0;
      have_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      cap_q     <= cap_d;
      data_q    <= data_d;
      wcnt_q    <= wcnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      counts_q  <= counts_d;
      fsel_q    <= fsel_d;
      fvalid_q  <= fvalid_d;
      fcount_q  <= fcount_d;
      serr_q    <= serr_d;
      qerr_q    <= qerr_d;
      have_q    <= have_d;
    end
  end

  always_comb begin
    edge_w    = (sel_in != sel_q);
    seq_set_w = 1'b0;
    state_d   = state_q;
    sel_d     = sel_in;
    cap_d     = cap_q;
    // data_in is staged one cycle so bit 0 lines up with the first RECV cycle
    data_d    = data_in;
    wcnt_d    = wcnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    counts_d  = counts_q;
    fsel_d    = fsel_q;
    fvalid_d  = 1'b0;
    fcount_d  = fcount_q;
    serr_d    = edge_w && ((state_q == WAIT) || (state_q == RECV));
    have_d    = have_q;

    case (state_q)
      WAIT: begin
        if (wcnt_q == 2'd0) state_d = RECV;
        else                wcnt_d  = wcnt_q - 2'd1;
      end
      RECV: begin
        shift_d   = {data_q, shift_q[NB-1:1]};
        bit_cnt_d = bit_cnt_q + CW'(1);
        if (bit_cnt_q == CW'(NB - 1)) state_d = DONE;
      end
      DONE: begin
        counts_d  = shift_q;
        fsel_d    = cap_q;
        fvalid_d  = 1'b1;
        fcount_d  = fcount_q + 16'd1;
        seq_set_w = have_q && (cap_q != (fsel_q + 2'd1));
        have_d    = 1'b1;
        state_d   = HUNT;
      end
      default: ;
    endcase

    // Any select change (re)starts a frame, overriding whatever the state chose
    if (edge_w) begin
      state_d   = (SYNC_OFFSET == 0) ? RECV : WAIT;
      wcnt_d    = 2'((SYNC_OFFSET > 0) ? (SYNC_OFFSET - 1) : 0);
      bit_cnt_d = '0;
      cap_d     = sel_in;
    end

    if (seq_set_w)      qerr_d = 1'b1;
    else if (clear_err) qerr_d = 1'b0;
    else                qerr_d = qerr_q;
  end

  assign counts_out  = counts_q;
  assign frame_sel   = fsel_q;
  assign frame_valid = fvalid_q;
  assign frame_count = fcount_q;
  assign sync_err    = serr_q;
  assign seq_err     = qerr_q;

endmodule

`default_nettype wire

// File: tb/tb_ro_data_receiver.sv
// ============================================================================
// tb_ro_data_receiver: scoreboard bench driving offset-0/1/3 receivers in parallel
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ro_data_receiver;

  localparam int NB = 256;
  localparam int ND = 3;
  localparam int SL = 264;

  typedef struct {
    bit            is_sync;
    logic [NB-1:0] counts;
    logic [1:0]    sel;
    logic [15:0]   fcount;
    logic          seq;
    int            cyc;
  } frame_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          data_in;
  logic [1:0]    sel_in;
  logic          clear_err;
  logic [NB-1:0] counts_o [ND];
  logic [1:0]    fsel_o   [ND];
  logic          fvalid_o [ND];
  logic [15:0]   fcnt_o   [ND];
  logic          serr_o   [ND];
  logic          qerr_o   [ND];

  frame_t        exp_q [ND][$];
  int            n_cmp = 0;
  int            n_err = 0;
  int            cyc = 0;

  // reference state, one entry per receiver
  logic [NB-1:0] m_counts [ND];
  logic [15:0]   m_count  [ND];
  logic [1:0]    m_last   [ND];
  bit            m_have   [ND];
  logic          m_seq    [ND];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int off_of(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 1 : 3);
  endfunction

  task automatic chk(input string name, input logic [NB-1:0] act, input logic [NB-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic check_pop(input int k, input bit is_sync);
    frame_t e;
    if (exp_q[k].size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL dut%0d unexpected pulse (sync=%0d) at cycle %0d: got pulse, required none",
               k, is_sync, cyc);
      return;
    end
    e = exp_q[k].pop_front();
    chk($sformatf("dut%0d kind", k), NB'(is_sync), NB'(e.is_sync));
    chk($sformatf("dut%0d cycle", k), NB'(cyc), NB'(e.cyc));
    if (!is_sync) begin
      chk($sformatf("dut%0d counts", k), counts_o[k], e.counts);
      chk($sformatf("dut%0d frame_sel", k), NB'(fsel_o[k]), NB'(e.sel));
      chk($sformatf("dut%0d frame_count", k), NB'(fcnt_o[k]), NB'(e.fcount));
      chk($sformatf("dut%0d seq_err", k), NB'(qerr_o[k]), NB'(e.seq));
    end
  endtask

  for (genvar g = 0; g < ND; g++) begin : g_dut
    ro_data_receiver #(
      .NUM_WORDS  (8),
      .WORD_W     (32),
      .SYNC_OFFSET((g == 0) ? 0 : ((g == 1) ? 1 : 3))
    ) u_dut (
      .data_clk   (clk),
      .reset      (reset),
      .data_in    (data_in),
      .sel_in     (sel_in),
      .clear_err  (clear_err),
      .counts_out (counts_o[g]),
      .frame_sel  (fsel_o[g]),
      .frame_valid(fvalid_o[g]),
      .frame_count(fcnt_o[g]),
      .sync_err   (serr_o[g]),
      .seq_err    (qerr_o[g])
    );

    always @(negedge clk) begin
      if (fvalid_o[g]) check_pop(g, 1'b0);
      if (serr_o[g])   check_pop(g, 1'b1);
    end
  end

  // Drive one select change followed by span cycles of serial data; the next
  // call (or reset) lands exactly span cycles after this frame's edge.
  task automatic send_frame(input logic [1:0] sel, input int span, input bit rst_abort,
                            input logic [NB-1:0] pay);
    logic   stream [SL];
    frame_t e;
    int     t;
    int     o;
    for (int i = 0; i < SL; i++) stream[i] = 1'($urandom);
    for (int n = 0; n < NB; n++) stream[1 + n] = pay[n];
    for (int i = 0; i < span; i++) begin
      @(negedge clk);
      if (i == 0) begin
        sel_in = sel;
        t = cyc + 1;
        for (int k = 0; k < ND; k++) begin
          o = off_of(k);
          e.is_sync = 1'b0;
          e.counts  = '0;
          e.sel     = sel;
          e.fcount  = '0;
          e.seq     = 1'b0;
          if (span >= o + 257) begin
            for (int n = 0; n < NB; n++) e.counts[n] = stream[o + n];
            m_count[k] = m_count[k] + 16'd1;
            if (m_have[k] && (sel != m_last[k] + 2'd1)) m_seq[k] = 1'b1;
            m_have[k]   = 1'b1;
            m_last[k]   = sel;
            m_counts[k] = e.counts;
            e.fcount    = m_count[k];
            e.seq       = m_seq[k];
            e.cyc       = t + o + 257;
            exp_q[k].push_back(e);
          end else if (!rst_abort) begin
            e.is_sync = 1'b1;
            e.cyc     = t + span;
            exp_q[k].push_back(e);
          end
        end
      end
      data_in = (i < SL) ? stream[i] : 1'($urandom);
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    reset = 1'b0;
    sel_in = 2'd0;
    data_in = 1'b0;
    clear_err = 1'b0;
    for (int k = 0; k < ND; k++) begin
      m_counts[k] = '0;
      m_count[k]  = '0;
      m_last[k]   = '0;
      m_have[k]   = 1'b0;
      m_seq[k]    = 1'b0;
    end
    #1;
    for (int k = 0; k < ND; k++)
      chk($sformatf("dut%0d async reset count", k), NB'(fcnt_o[k]), '0);
    repeat (n) @(negedge clk);
    for (int k = 0; k < ND; k++) begin
      chk($sformatf("dut%0d reset counts", k), counts_o[k], '0);
      chk($sformatf("dut%0d reset outs", k),
          NB'({fsel_o[k], fvalid_o[k], fcnt_o[k], serr_o[k], qerr_o[k]}), '0);
    end
    reset = 1'b1;
  endtask

  task automatic check_idle();
    for (int k = 0; k < ND; k++) begin
      chk($sformatf("dut%0d pending", k), NB'(exp_q[k].size()), '0);
      chk($sformatf("dut%0d idle counts", k), counts_o[k], m_counts[k]);
      chk($sformatf("dut%0d idle frame_count", k), NB'(fcnt_o[k]), NB'(m_count[k]));
      chk($sformatf("dut%0d idle frame_sel", k), NB'(fsel_o[k]), NB'(m_last[k]));
      chk($sformatf("dut%0d idle seq_err", k), NB'(qerr_o[k]), NB'(m_seq[k]));
    end
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    for (int k = 0; k < ND; k++) m_seq[k] = 1'b0;
  endtask

  function automatic logic [NB-1:0] rand_pay();
    logic [NB-1:0] p;
    for (int w = 0; w < 8; w++) p[w*32 +: 32] = $urandom;
    return p;
  endfunction

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [NB-1:0] pay;
    logic [1:0]    s;
    int            span;
    reset = 1'b0;
    data_in = 1'b0;
    sel_in = 2'd0;
    clear_err = 1'b0;
    do_reset(3);
    check_idle();

    for (int w = 0; w < 8; w++) pay[w*32 +: 32] = 32'(w + 1);
    send_frame(2'd1, 300, 1'b0, pay);
    check_idle();

    for (int i = 0; i < 4; i++) begin
      s = 2'(i + 2);
      send_frame(s, (i == 3) ? 300 : int'($urandom_range(260, 270)), 1'b0, rand_pay());
    end
    check_idle();

    send_frame(2'd3, 101, 1'b0, rand_pay());
    send_frame(2'd2, 300, 1'b0, rand_pay());
    check_idle();

    send_frame(2'd3, 300, 1'b0, rand_pay());
    send_frame(2'd1, 300, 1'b0, rand_pay());
    check_idle();
    pulse_clear();
    check_idle();

    // select change in the publish cycle of the offset-1 receiver
    send_frame(2'd2, 258, 1'b0, rand_pay());
    send_frame(2'd3, 300, 1'b0, rand_pay());
    check_idle();
    pulse_clear();

    send_frame(2'd1, 2, 1'b0, rand_pay());
    send_frame(2'd0, 300, 1'b0, rand_pay());
    check_idle();

    for (int w = 0; w < 8; w++) pay[w*32 +: 32] = 32'hA5A5_A5A5;
    send_frame(2'd1, 300, 1'b0, pay);
    check_idle();

    send_frame(2'd2, 201, 1'b1, rand_pay());
    do_reset(4);
    send_frame(2'd1, 300, 1'b0, rand_pay());
    check_idle();

    s = 2'd1;
    for (int i = 0; i < 10; i++) begin
      s = s + 2'($urandom_range(1, 3));
      span = (i == 9) ? 300 : int'($urandom_range(1, 400));
      send_frame(s, span, 1'b0, rand_pay());
    end
    check_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
